// File: rtl/vault_ram_ctrl.sv
// rtl/vault_ram_ctrl.sv - arbiter and sequencer for the 16x256 password storage RAM
// Owns occupancy; the RAM port is shared by store, lookup and wipe with wipe > store > lookup.
module vault_ram_ctrl #(
  parameter int DW    = 256,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic [AW-1:0] st_slot,
  input  logic          rq_valid,
  input  logic [AW-1:0] rq_idx,
  output logic          rq_ready,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  input  logic          wipe_req,
  output logic          wipe_busy,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, WR, RD, WIPE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] slot_q, slot_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic          st_fire, rq_fire, rd_err, wipe_last;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign st_slot   = count_q[AW-1:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign st_fire   = st_valid & st_ready;
  assign rq_fire   = rq_valid & rq_ready;
  // count already reflects any store that finished in the previous cycle
  assign rd_err    = ({1'b0, idx_q} >= count_q);
  assign wipe_last = (wcnt_q == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wcnt_q      <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wcnt_q      <= wcnt_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wipe_req)             state_d = WIPE;
        else if (st_valid && !full) state_d = WR;
        else if (rq_valid)        state_d = RD;
      end
      WR:      state_d = IDLE;
      RD:      state_d = IDLE;
      WIPE:    if (wipe_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    wcnt_d      = wcnt_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = (state_q == RD);
    if (st_fire) begin
      data_d = st_data;
      slot_d = count_q[AW-1:0];
    end
    if (rq_fire) idx_d = rq_idx;
    case (state_q)
      WR: count_d = count_q + (AW+1)'(1);
      RD: begin
        rsp_err_d  = rd_err;
        rsp_data_d = rd_err ? '0 : ram_q;
      end
      WIPE: begin
        wcnt_d = wcnt_q + AW'(1);
        if (wipe_last) begin
          wcnt_d  = '0;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    st_ready  = 1'b0;
    rq_ready  = 1'b0;
    wipe_busy = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_data  = '0;
    case (state_q)
      IDLE: begin
        st_ready = !wipe_req && !full;
        rq_ready = !wipe_req && !(st_valid && !full);
      end
      WR: begin
        ram_we   = 1'b1;
        ram_addr = slot_q;
        ram_data = data_q;
      end
      RD: ram_addr = idx_q;
      WIPE: begin
        wipe_busy = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = wcnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/vault_ram_ctrl.md
Name: vault_ram_ctrl

Overview:
- Sequencing controller and arbiter in front of the 16-entry x 256-bit password storage RAM.
- Shares the single RAM port among three requesters: a store channel (append to the next free slot), a lookup channel (read by index) and a wipe command (zero every slot).
- Owns the occupancy count and full/empty status; the RAM itself only stores data.

Parameters:
DW, 256, entry data width
AW, 4, RAM address width
DEPTH, 16, number of slots (must equal 2**AW)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
st_valid  in  1  store request
st_data  in  DW  entry to store
st_ready  out  1  store accepted this cycle (transfer when st_valid & st_ready)
st_slot  out  AW  slot assigned to the accepted store (valid when st_ready)
rq_valid  in  1  lookup request
rq_idx  in  AW  slot to read
rq_ready  out  1  lookup accepted this cycle
rsp_valid  out  1  one-cycle lookup response strobe
rsp_data  out  DW  lookup data
rsp_err  out  1  lookup hit an unused slot
wipe_req  in  1  wipe command (level-sampled in IDLE)
wipe_busy  out  1  wipe in progress
count  out  AW+1  used slots, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
ram_data  out  DW  RAM write data
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write enable
ram_q  in  DW  RAM combinational read data

Behaviour:
- States: IDLE, WR, RD, WIPE.
- Reset (rst=0 at a clock edge):
  - state=IDLE, count=0, wipe counter=0.
  - ram_we=0, ram_addr=0, ram_data=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, wipe_busy=0.
  - Reset does not clear RAM contents.
  - Reset overrides any operation in flight, including mid-wipe. RAM contents after an aborted wipe are unspecified; count is still 0.
- IDLE arbitration, fixed priority wipe > store > lookup:
  - st_ready = IDLE & !wipe_req & !full.
  - rq_ready = IDLE & !wipe_req & !(st_valid & !full).
  - st_ready and rq_ready are combinational and 0 in all other states.
  - The loser of a simultaneous request is stalled, never dropped; the requester holds valid.
- In IDLE: ram_we=0, ram_addr=0, ram_data=0.
- Store accepted at cycle T:
  - st_slot=count[AW-1:0]; data and slot are latched.
  - T+1 (WR): ram_we=1, ram_addr=slot, ram_data=latched data. count increments at the end of T+1.
  - T+2: IDLE. Maximum throughput is 1 store per 2 cycles.
- Full: st_ready held 0. The store stalls until a wipe frees space; count never exceeds DEPTH.
- Lookup accepted at cycle T:
  - T+1 (RD): ram_we=0, ram_addr=idx. At the end of T+1, rsp_err <= (idx >= count) and rsp_data <= err ? 0 : ram_q.
  - T+2: rsp_valid=1 for exactly one cycle; state=IDLE. rsp_data/rsp_err hold until the next response.
- Wipe taken at cycle T (wipe_req=1 in IDLE):
  - T+1..T+16 (WIPE): wipe_busy=1, ram_we=1, ram_data=0, ram_addr=0,1,…,15 in order.
  - count clears to 0 at the end of T+16. T+17: IDLE.
  - wipe_req is ignored while in WIPE. If still high on return to IDLE, another wipe starts.
- The lookup error check uses count after any preceding store has completed. A lookup following a store to slot N in the same request burst reads the new data.
- full/empty are combinational from count.

Test Plan:
- Reset, then stores of 0xA, 0xB, 0xC back-to-back with st_valid held -> accepts every 2nd cycle with st_slot 0,1,2; ram_we pulses at addr 0,1,2 with the matching data; count=3, empty=0.
- Lookup idx=1 after the above -> rsp_valid exactly 2 cycles after acceptance, rsp_data=0xB, rsp_err=0. Lookup idx=5 -> rsp_err=1, rsp_data=0.
- 16 stores then a 17th held for 10 cycles -> full=1, st_ready=0 throughout, count=16, no ram_we.
- wipe_req, st_valid and rq_valid all raised in the same IDLE cycle -> wipe wins: wipe_busy for 16 cycles, writes of 0 to addr 0..15, count=0. Then the store is accepted to slot 0, then the lookup is accepted.
- st_valid and rq_valid (idx=0) simultaneous on an empty RAM -> store first, lookup next IDLE; rsp_err=0, rsp_data equals the stored word.
- rst driven low on the 5th WIPE cycle -> at the next edge state=IDLE, count=0, wipe_busy=0, ram_we=0; after release a new store lands in slot 0.
